// File: rtl/spu_regfile_mp.sv
// Multi-pipe SPU register file: NUM_PIPES write ports, RD_PER_PIPE read ports per pipe,
// optional write->read bypass, and a clear sequencer that zeroes the array after reset.
module spu_regfile_mp #(
    parameter int WIDTH       = 128,
    parameter int SIZE        = 128,
    parameter int NUM_PIPES   = 2,
    parameter int RD_PER_PIPE = 3,
    parameter int BYPASS      = 1,
    parameter int LOGSIZE     = (SIZE > 1) ? $clog2(SIZE) : 1,
    parameter int NRD         = NUM_PIPES * RD_PER_PIPE
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear_req,
    input  logic [NRD*LOGSIZE-1:0]         rd_addr,
    output logic [NRD*WIDTH-1:0]           rd_data,
    input  logic [NUM_PIPES-1:0]           wr_en,
    input  logic [NUM_PIPES*LOGSIZE-1:0]   wr_addr,
    input  logic [NUM_PIPES*WIDTH-1:0]     wr_data,
    output logic                           rf_ready,
    output logic                           wr_conflict,
    output logic                           wr_dropped
);

    localparam logic [LOGSIZE:0]   SIZE_W   = (LOGSIZE + 1)'(SIZE);
    localparam logic [LOGSIZE-1:0] LAST_IDX = LOGSIZE'(SIZE - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t               state_reg, state_next;
    logic [LOGSIZE-1:0]   clr_cnt_reg, clr_cnt_next;
    logic                 wr_conflict_reg, wr_dropped_reg;
    logic                 conflict_next;
    logic [NUM_PIPES-1:0] wr_valid;
    logic [WIDTH-1:0]     mem [SIZE];

    function automatic logic addr_ok(input logic [LOGSIZE-1:0] a);
        return {1'b0, a} < SIZE_W;
    endfunction

    // A write only counts when the array is live and the address exists.
    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_wr_valid
        assign wr_valid[gi] = wr_en[gi] && (state_reg == READY) &&
                              addr_ok(wr_addr[gi*LOGSIZE +: LOGSIZE]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= INIT;
            clr_cnt_reg     <= '0;
            wr_conflict_reg <= 1'b0;
            wr_dropped_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            clr_cnt_reg     <= clr_cnt_next;
            wr_conflict_reg <= conflict_next;
            wr_dropped_reg  <= (state_reg == INIT) && (|wr_en);
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            INIT: begin
                if (clr_cnt_reg == LAST_IDX) begin
                    state_next   = READY;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            READY: begin
                if (clear_req) begin
                    state_next   = INIT;
                    clr_cnt_next = '0;
                end
            end
            default: begin
                state_next   = INIT;
                clr_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        rf_ready    = (state_reg == READY);
        wr_conflict = wr_conflict_reg;
        wr_dropped  = wr_dropped_reg;
    end

    always_comb begin
        conflict_next = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            for (int j = i + 1; j < NUM_PIPES; j++) begin
                if (wr_valid[i] && wr_valid[j] &&
                    wr_addr[i*LOGSIZE +: LOGSIZE] == wr_addr[j*LOGSIZE +: LOGSIZE])
                    conflict_next = 1'b1;
            end
        end
    end

    // Ascending pipe order makes the highest-index pipe win on a shared address.
    always_ff @(posedge clk) begin
        if (state_reg == INIT) begin
            mem[clr_cnt_reg] <= '0;
        end else begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                if (wr_valid[i])
                    mem[wr_addr[i*LOGSIZE +: LOGSIZE]] <= wr_data[i*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [LOGSIZE-1:0] ra;
        logic [WIDTH-1:0]   rd_val;

        assign ra = rd_addr[gi*LOGSIZE +: LOGSIZE];

        always_comb begin
            rd_val = '0;
            if (state_reg == READY && addr_ok(ra))
                rd_val = mem[ra];
            for (int i = 0; i < NUM_PIPES; i++) begin
                if (BYPASS != 0 && wr_valid[i] && wr_addr[i*LOGSIZE +: LOGSIZE] == ra)
                    rd_val = wr_data[i*WIDTH +: WIDTH];
            end
        end

        assign rd_data[gi*WIDTH +: WIDTH] = rd_val;
    end

endmodule

// File: tb/tb_spu_regfile_mp.sv
// Directed bench for spu_regfile_mp (default parameters, BYPASS=1): init sweep timing,
// writes, bypass, conflicts, dropped writes, clear request and reset during the sweep.
module tb_spu_regfile_mp;

    localparam int W  = 128;
    localparam int LS = 7;
    localparam int NP = 2;
    localparam int NR = 6;

    logic              clk;
    logic              rst_n;
    logic              clear_req;
    logic [NR*LS-1:0]  rd_addr;
    logic [NR*W-1:0]   rd_data;
    logic [NP-1:0]     wr_en;
    logic [NP*LS-1:0]  wr_addr;
    logic [NP*W-1:0]   wr_data;
    logic              rf_ready;
    logic              wr_conflict;
    logic              wr_dropped;

    int checks = 0;
    int errors = 0;

    localparam logic [W-1:0] D_A5 = {16{8'hA5}};
    localparam logic [W-1:0] D_11 = {16{8'h11}};
    localparam logic [W-1:0] D_22 = {16{8'h22}};
    localparam logic [W-1:0] D_X  = {4{32'hDEAD_BEEF}};
    localparam logic [W-1:0] D_Y  = {4{32'h0123_4567}};

    spu_regfile_mp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_req   (clear_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rf_ready    (rf_ready),
        .wr_conflict (wr_conflict),
        .wr_dropped  (wr_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rd(input int p);
        return rd_data[p*W +: W];
    endfunction

    task automatic set_rd(input int p, input logic [LS-1:0] a);
        rd_addr[p*LS +: LS] = a;
    endtask

    task automatic set_rd_all(input logic [LS-1:0] a);
        for (int p = 0; p < NR; p++) set_rd(p, a);
    endtask

    task automatic wr(input int p, input logic [LS-1:0] a, input logic [W-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*LS +: LS] = a;
        wr_data[p*W +: W]   = d;
    endtask

    task automatic wr_idle;
        wr_en = '0;
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] exp);
        #1;
        for (int p = 0; p < NR; p++) chk($sformatf("%s_p%0d", tag, p), rd(p), exp);
    endtask

    // rf_ready must stay low until exactly 128 edges have elapsed.
    task automatic sweep(input string tag);
        for (int k = 1; k <= 128; k++) begin
            tick;
            chk($sformatf("%s_ready_e%0d", tag, k), W'(rf_ready), W'(k == 128));
        end
    endtask

    initial begin
        rst_n = 1'b0; clear_req = 1'b0;
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        repeat (2) tick;
        chk("reset_ready", W'(rf_ready), '0);
        chk("reset_conflict", W'(wr_conflict), '0);
        chk("reset_dropped", W'(wr_dropped), '0);
        chk("reset_rd0", rd(0), '0);

        // T1 + T4: sweep timing, with a dropped dual write to already-cleared r2/r3
        rst_n = 1'b1;
        for (int e = 1; e <= 128; e++) begin
            tick;
            chk($sformatf("t1_ready_e%0d", e), W'(rf_ready), W'(e == 128));
            if (e == 10) begin
                wr(0, 7'd2, D_X);
                wr(1, 7'd3, D_Y);
            end else if (e == 11) begin
                chk("t4_dropped_pulse", W'(wr_dropped), 1);
                wr_idle;
            end else if (e == 12) begin
                chk("t4_dropped_clear", W'(wr_dropped), 0);
            end
        end
        set_rd_all(7'd0);
        chk_all("t1_zero", '0);
        for (int p = 0; p < NR; p++) set_rd(p, LS'(2 + (p % 2)));
        chk_all("t4_r2r3_zero", '0);

        // T2: single write with same-cycle bypass
        wr(0, 7'd5, D_A5);
        set_rd_all(7'd5);
        chk_all("t2_bypass", D_A5);
        tick;
        wr_idle;
        chk("t2_no_conflict", W'(wr_conflict), 0);
        chk_all("t2_stored", D_A5);

        // T3: both pipes hit r9, pipe 1 wins
        wr(0, 7'd9, D_11);
        wr(1, 7'd9, D_22);
        set_rd_all(7'd9);
        chk_all("t3_bypass", D_22);
        tick;
        wr_idle;
        chk("t3_conflict_pulse", W'(wr_conflict), 1);
        chk_all("t3_stored", D_22);
        tick;
        chk("t3_conflict_clear", W'(wr_conflict), 0);

        // Different addresses in one cycle both commit
        wr(0, 7'd10, D_X);
        wr(1, 7'd11, D_Y);
        set_rd(0, 7'd10); set_rd(3, 7'd11);
        #1;
        chk("diff_bypass0", rd(0), D_X);
        chk("diff_bypass3", rd(3), D_Y);
        tick;
        wr_idle;
        chk("diff_no_conflict", W'(wr_conflict), 0);
        set_rd(1, 7'd11); set_rd(4, 7'd10);
        #1;
        chk("diff_r10", rd(4), D_X);
        chk("diff_r11", rd(1), D_Y);

        // T5: fill r0..r3, clear with a concurrent write, second clear_req ignored in INIT
        wr(0, 7'd0, D_X); wr(1, 7'd1, D_Y);
        tick;
        wr(0, 7'd2, D_11); wr(1, 7'd3, D_22);
        tick;
        wr_idle;
        set_rd(2, 7'd3);
        #1;
        chk("t5_r3_filled", rd(2), D_22);
        wr(1, 7'd3, D_A5);
        clear_req = 1'b1;
        tick;
        wr_idle;
        clear_req = 1'b0;
        set_rd_all(7'd5);
        chk("t5_ready_low", W'(rf_ready), 0);
        chk_all("t5_init_forced0", '0);
        for (int k = 1; k <= 128; k++) begin
            clear_req = (k == 50);
            tick;
            chk($sformatf("t5_ready_e%0d", k), W'(rf_ready), W'(k == 128));
        end
        clear_req = 1'b0;
        for (int p = 0; p < 4; p++) set_rd(p, LS'(p));
        set_rd(4, 7'd9); set_rd(5, 7'd10);
        chk_all("t5_cleared", '0);

        // T6: reset at clr_cnt=60 with a pending wr_dropped pulse
        wr(0, 7'd7, D_X);
        tick;
        wr_idle;
        clear_req = 1'b1;
        tick;
        clear_req = 1'b0;
        repeat (59) tick;
        wr(0, 7'd7, D_Y);
        tick;
        wr_idle;
        chk("t6_dropped_pulse", W'(wr_dropped), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_ready", W'(rf_ready), 0);
        chk("t6_async_dropped", W'(wr_dropped), 0);
        tick;
        rst_n = 1'b1;
        sweep("t6");
        set_rd_all(7'd7);
        chk_all("t6_r7_zero", '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
